// File: rtl/hazard3_trigger_unit_if.sv
// CSR configuration port of the Hazard3 debug trigger unit.
// The core's CSR block is the master; the trigger unit is the slave.
interface hazard3_trigger_unit_if #(
    parameter int W_DATA = 32
);
    logic [11:0]       cfg_addr;
    logic              cfg_wen;
    logic [W_DATA-1:0] cfg_wdata;
    logic [W_DATA-1:0] cfg_rdata;

    modport master (output cfg_addr, output cfg_wen, output cfg_wdata, input cfg_rdata);
    modport slave  (input cfg_addr, input cfg_wen, input cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/hazard3_trigger_unit.sv
// Hazard3 debug trigger unit: N mcontrol address-match triggers with chaining,
// plus an optional icount trigger, all configured through tselect/tdata1/tdata2.
module hazard3_trigger_unit #(
    parameter int N_MCONTROL  = 4,
    parameter int HAVE_ICOUNT = 1,
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int W_ICOUNT    = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard3_trigger_unit_if.slave cfg,
    input  logic                  trig_m_en,
    input  logic                  m_mode,
    input  logic                  d_mode,
    input  logic [W_ADDR-1:0]     exec_pc,
    input  logic                  exec_valid,
    input  logic [W_ADDR-1:0]     mem_addr,
    input  logic                  mem_valid,
    input  logic                  mem_write,
    input  logic                  retire,
    input  logic                  trap_enter,
    output logic                  break_exec,
    output logic                  break_mem,
    output logic                  break_icount,
    output logic                  break_d_mode
);

    localparam int N_TRIG = N_MCONTROL + ((HAVE_ICOUNT != 0) ? 1 : 0);
    localparam int W_SEL  = (N_TRIG > 1) ? $clog2(N_TRIG) : 1;

    localparam logic [11:0] ADDR_TSELECT = 12'h7a0;
    localparam logic [11:0] ADDR_TDATA1  = 12'h7a1;
    localparam logic [11:0] ADDR_TDATA2  = 12'h7a2;
    localparam logic [11:0] ADDR_TINFO   = 12'h7a4;

    function automatic logic addr_match(input logic [1:0] mode, input logic [W_ADDR-1:0] addr,
                                        input logic [W_ADDR-1:0] t);
        logic [W_ADDR-1:0] mask;
        mask = ~(t ^ (t + W_ADDR'(1)));
        case (mode)
            2'd0:    return addr == t;
            2'd1:    return (addr & mask) == (t & mask);
            2'd2:    return addr >= t;
            default: return addr < t;
        endcase
    endfunction

    // Unsupported match encodings collapse to exact match.
    function automatic logic [1:0] legal_match(input logic [3:0] m);
        return (m > 4'd3) ? 2'd0 : m[1:0];
    endfunction

    logic [W_SEL-1:0]      tselect;
    logic [N_MCONTROL-1:0] dmode, action, chain, hit, mm, uu, execute, store, load;
    logic [1:0]            match  [N_MCONTROL];
    logic [W_ADDR-1:0]     tdata2 [N_MCONTROL];

    logic                  ic_dmode, ic_action, ic_hit, ic_m, ic_u, ic_pending;
    logic [W_ICOUNT-1:0]   ic_count;

    logic                  wr_t1, wr_t2, sel_mc, sel_ic, ic_wr, ic_dec;
    logic [31:0]           mc_rd1;
    logic [W_ADDR-1:0]     mc_rd2;
    logic [N_MCONTROL-1:0] raw_exec, raw_mem, hit_set, run_mask;
    logic                  acc_exec, acc_mem, qual, brk_exec, brk_mem, brk_d;

    assign wr_t1  = cfg.cfg_wen && (cfg.cfg_addr == ADDR_TDATA1);
    assign wr_t2  = cfg.cfg_wen && (cfg.cfg_addr == ADDR_TDATA2);
    assign sel_ic = (HAVE_ICOUNT != 0) && (tselect == W_SEL'(N_MCONTROL));
    assign ic_wr  = wr_t1 && sel_ic && !(ic_dmode && !d_mode);
    assign ic_dec = (HAVE_ICOUNT != 0) && retire && (ic_count != '0) && !d_mode &&
                    (m_mode ? ic_m : ic_u) && (ic_action ? ic_dmode : trig_m_en);

    always_comb begin
        raw_exec = '0;
        raw_mem  = '0;
        for (int i = 0; i < N_MCONTROL; i++) begin
            raw_exec[i] = execute[i] && exec_valid && !d_mode && (m_mode ? mm[i] : uu[i]) &&
                          addr_match(match[i], exec_pc, tdata2[i]);
            raw_mem[i]  = (mem_write ? store[i] : load[i]) && mem_valid && !d_mode &&
                          (m_mode ? mm[i] : uu[i]) && addr_match(match[i], mem_addr, tdata2[i]);
        end
    end

    // Walk chain runs; a run closes at the first trigger with chain=0 and uses its action.
    always_comb begin
        hit_set  = '0;
        run_mask = '0;
        acc_exec = 1'b1;
        acc_mem  = 1'b1;
        qual     = 1'b0;
        brk_exec = 1'b0;
        brk_mem  = 1'b0;
        brk_d    = 1'b0;
        for (int i = 0; i < N_MCONTROL; i++) begin
            run_mask[i] = 1'b1;
            acc_exec    = acc_exec && raw_exec[i];
            acc_mem     = acc_mem && raw_mem[i];
            if (!chain[i]) begin
                qual = action[i] ? dmode[i] : trig_m_en;
                if (acc_exec && qual) begin
                    hit_set  = hit_set | run_mask;
                    brk_exec = 1'b1;
                    brk_d    = brk_d | action[i];
                end
                if (acc_mem && qual) begin
                    hit_set = hit_set | run_mask;
                    brk_mem = 1'b1;
                    brk_d   = brk_d | action[i];
                end
                run_mask = '0;
                acc_exec = 1'b1;
                acc_mem  = 1'b1;
            end
        end
    end

    assign break_exec   = brk_exec;
    assign break_mem    = brk_mem;
    assign break_icount = ic_pending;
    assign break_d_mode = brk_d || (ic_pending && ic_action);

    always_comb begin
        sel_mc = 1'b0;
        mc_rd1 = '0;
        mc_rd2 = '0;
        for (int i = 0; i < N_MCONTROL; i++) begin
            if (tselect == W_SEL'(i)) begin
                sel_mc = 1'b1;
                mc_rd1 = {4'd2, dmode[i], 6'd31, hit[i], 1'b0, 1'b0, 2'b00, 3'b000, action[i],
                          chain[i], 2'b00, match[i], mm[i], 2'b00, uu[i], execute[i], store[i],
                          load[i]};
                mc_rd2 = tdata2[i];
            end
        end
    end

    always_comb begin
        cfg.cfg_rdata = '0;
        case (cfg.cfg_addr)
            ADDR_TSELECT: cfg.cfg_rdata = W_DATA'(tselect);
            ADDR_TDATA1: begin
                if (sel_mc)
                    cfg.cfg_rdata = W_DATA'(mc_rd1);
                else if (sel_ic)
                    cfg.cfg_rdata = W_DATA'({4'd3, ic_dmode, 2'b00, ic_hit, ic_count, ic_m,
                                             2'b00, ic_u, 5'b00000, ic_action});
            end
            ADDR_TDATA2: if (sel_mc) cfg.cfg_rdata = W_DATA'(mc_rd2);
            ADDR_TINFO:  cfg.cfg_rdata = sel_mc ? W_DATA'(4) : (sel_ic ? W_DATA'(8) : W_DATA'(1));
            default:     cfg.cfg_rdata = '0;
        endcase
    end

    // mcontrol state: CSR writes take priority over hit capture in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tselect <= '0;
            dmode   <= '0;
            action  <= '0;
            chain   <= '0;
            hit     <= '0;
            mm      <= '0;
            uu      <= '0;
            execute <= '0;
            store   <= '0;
            load    <= '0;
            for (int i = 0; i < N_MCONTROL; i++) begin
                match[i]  <= '0;
                tdata2[i] <= '0;
            end
        end else begin
            if (cfg.cfg_wen && (cfg.cfg_addr == ADDR_TSELECT))
                tselect <= W_SEL'(cfg.cfg_wdata[2:0]);
            for (int i = 0; i < N_MCONTROL; i++) begin
                if (wr_t1 && (tselect == W_SEL'(i)) && !(dmode[i] && !d_mode)) begin
                    dmode[i]   <= cfg.cfg_wdata[27];
                    action[i]  <= cfg.cfg_wdata[27] && cfg.cfg_wdata[12];
                    chain[i]   <= (i == N_MCONTROL - 1) ? 1'b0 : cfg.cfg_wdata[11];
                    match[i]   <= legal_match(cfg.cfg_wdata[10:7]);
                    mm[i]      <= cfg.cfg_wdata[6];
                    uu[i]      <= cfg.cfg_wdata[3];
                    execute[i] <= cfg.cfg_wdata[2];
                    store[i]   <= cfg.cfg_wdata[1];
                    load[i]    <= cfg.cfg_wdata[0];
                    hit[i]     <= cfg.cfg_wdata[20];
                end else if (hit_set[i]) begin
                    hit[i] <= 1'b1;
                end
                if (wr_t2 && (tselect == W_SEL'(i)) && !(dmode[i] && !d_mode))
                    tdata2[i] <= cfg.cfg_wdata[W_ADDR-1:0];
            end
        end
    end

    // icount state: a TDATA1 write suppresses any decrement in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ic_dmode   <= 1'b0;
            ic_action  <= 1'b0;
            ic_hit     <= 1'b0;
            ic_m       <= 1'b0;
            ic_u       <= 1'b0;
            ic_count   <= '0;
            ic_pending <= 1'b0;
        end else if (ic_wr) begin
            ic_dmode   <= cfg.cfg_wdata[27];
            ic_action  <= cfg.cfg_wdata[27] && cfg.cfg_wdata[0];
            ic_hit     <= cfg.cfg_wdata[24];
            ic_count   <= cfg.cfg_wdata[10 +: W_ICOUNT];
            ic_m       <= cfg.cfg_wdata[9];
            ic_u       <= cfg.cfg_wdata[6];
            ic_pending <= 1'b0;
        end else begin
            if (ic_dec)
                ic_count <= ic_count - W_ICOUNT'(1);
            if (ic_dec && (ic_count == W_ICOUNT'(1))) begin
                ic_pending <= 1'b1;
                ic_hit     <= 1'b1;
            end else if (trap_enter) begin
                ic_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hazard3_trigger_unit.sv
// Directed bench for hazard3_trigger_unit: exact/NAPOT/range matching, chaining,
// write protection and legalisation, icount, tselect range and async reset.
module tb_hazard3_trigger_unit;

    localparam logic [11:0] A_TSEL = 12'h7a0;
    localparam logic [11:0] A_TD1  = 12'h7a1;
    localparam logic [11:0] A_TD2  = 12'h7a2;
    localparam logic [11:0] A_INFO = 12'h7a4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trig_m_en, m_mode, d_mode;
    logic [31:0] exec_pc, mem_addr;
    logic        exec_valid, mem_valid, mem_write, retire, trap_enter;
    logic        break_exec, break_mem, break_icount, break_d_mode;
    logic [31:0] rd;
    int          checks = 0;
    int          errors = 0;

    hazard3_trigger_unit_if #(.W_DATA(32)) cfg_if ();

    hazard3_trigger_unit #(
        .N_MCONTROL(4), .HAVE_ICOUNT(1), .W_ADDR(32), .W_DATA(32), .W_ICOUNT(14)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg(cfg_if),
        .trig_m_en(trig_m_en), .m_mode(m_mode), .d_mode(d_mode),
        .exec_pc(exec_pc), .exec_valid(exec_valid),
        .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_write(mem_write),
        .retire(retire), .trap_enter(trap_enter),
        .break_exec(break_exec), .break_mem(break_mem),
        .break_icount(break_icount), .break_d_mode(break_d_mode)
    );

    always #5 clk = ~clk;

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        cfg_if.cfg_addr  = a;
        cfg_if.cfg_wdata = d;
        cfg_if.cfg_wen   = 1'b1;
        @(posedge clk);
        #1;
        cfg_if.cfg_wen = 1'b0;
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
        cfg_if.cfg_addr = a;
        #1;
        d = cfg_if.cfg_rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({break_exec, break_mem, break_icount, break_d_mode} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_breaks got %b want 0000",
                     {break_exec, break_mem, break_icount, break_d_mode});
        end
        csr_rd(A_TSEL, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_tselect got %h want 0", rd); end
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h23E0_0000) begin errors++; $display("FAIL reset_tdata1 got %h want 23e00000", rd); end
        csr_rd(A_TD2, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_tdata2 got %h want 0", rd); end
        csr_rd(A_INFO, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL reset_tinfo got %h want 4", rd); end
        csr_wr(A_TSEL, 32'd4);
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h3000_0000) begin errors++; $display("FAIL reset_icount got %h want 30000000", rd); end
        csr_wr(A_TSEL, 32'd0);
    endtask

    task automatic test_exec_exact();
        d_mode = 0; m_mode = 1; trig_m_en = 1;
        csr_wr(A_TSEL, 32'd0);
        csr_wr(A_TD2, 32'h100);
        csr_wr(A_TD1, 32'h2000_0044);
        exec_pc = 32'h100; exec_valid = 1;
        #1;
        checks++;
        if ({break_exec, break_d_mode} !== 2'b10) begin
            errors++; $display("FAIL exec_hit exec/dmode got %b want 10", {break_exec, break_d_mode});
        end
        tick();
        exec_valid = 0;
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h23F0_0044) begin errors++; $display("FAIL exec_hitbit got %h want 23f00044", rd); end
        exec_pc = 32'h104; exec_valid = 1;
        #1;
        checks++;
        if (break_exec !== 1'b0) begin errors++; $display("FAIL exec_miss got %b want 0", break_exec); end
        exec_pc = 32'h100; trig_m_en = 0;
        #1;
        checks++;
        if (break_exec !== 1'b0) begin errors++; $display("FAIL exec_m_en_off got %b want 0", break_exec); end
        exec_valid = 0; trig_m_en = 1;
        csr_wr(A_TD1, 32'h0);
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h23E0_0000) begin errors++; $display("FAIL exec_hitclear got %h want 23e00000", rd); end
    endtask

    task automatic test_napot();
        d_mode = 1;
        csr_wr(A_TSEL, 32'd1);
        csr_wr(A_TD2, 32'h2007);
        csr_wr(A_TD1, 32'h2800_108A);
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h2BE0_108A) begin errors++; $display("FAIL napot_cfg got %h want 2be0108a", rd); end
        d_mode = 0; m_mode = 0;
        mem_addr = 32'h2004; mem_write = 1; mem_valid = 1;
        #1;
        checks++;
        if ({break_mem, break_d_mode} !== 2'b11) begin
            errors++; $display("FAIL napot_store mem/dmode got %b want 11", {break_mem, break_d_mode});
        end
        mem_write = 0;
        #1;
        checks++;
        if (break_mem !== 1'b0) begin errors++; $display("FAIL napot_load got %b want 0", break_mem); end
        mem_write = 1; mem_addr = 32'h2010;
        #1;
        checks++;
        if (break_mem !== 1'b0) begin errors++; $display("FAIL napot_above got %b want 0", break_mem); end
        mem_addr = 32'h1FFC;
        #1;
        checks++;
        if (break_mem !== 1'b0) begin errors++; $display("FAIL napot_below got %b want 0", break_mem); end
        mem_valid = 0; m_mode = 1; d_mode = 1;
        csr_wr(A_TD1, 32'h0);
        d_mode = 0;
    endtask

    task automatic test_chain();
        d_mode = 0; m_mode = 1; trig_m_en = 1;
        csr_wr(A_TSEL, 32'd0);
        csr_wr(A_TD2, 32'h1000);
        csr_wr(A_TD1, 32'h2000_0941);
        csr_wr(A_TSEL, 32'd1);
        csr_wr(A_TD2, 32'h2000);
        csr_wr(A_TD1, 32'h2000_01C1);
        mem_write = 0; mem_addr = 32'h1800; mem_valid = 1;
        #1;
        checks++;
        if ({break_mem, break_exec} !== 2'b10) begin
            errors++; $display("FAIL chain_fire mem/exec got %b want 10", {break_mem, break_exec});
        end
        tick();
        mem_valid = 0;
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h23F0_01C1) begin errors++; $display("FAIL chain_hit1 got %h want 23f001c1", rd); end
        csr_wr(A_TSEL, 32'd0);
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h23F0_0941) begin errors++; $display("FAIL chain_hit0 got %h want 23f00941", rd); end
        mem_addr = 32'h2800; mem_valid = 1;
        #1;
        checks++;
        if (break_mem !== 1'b0) begin errors++; $display("FAIL chain_t0_alone got %b want 0", break_mem); end
        mem_addr = 32'h0800;
        #1;
        checks++;
        if (break_mem !== 1'b0) begin errors++; $display("FAIL chain_t1_only got %b want 0", break_mem); end
        mem_valid = 0;
        csr_wr(A_TD1, 32'h0);
        csr_wr(A_TSEL, 32'd1);
        csr_wr(A_TD1, 32'h0);
    endtask

    task automatic test_protection();
        d_mode = 1;
        csr_wr(A_TSEL, 32'd2);
        csr_wr(A_TD2, 32'h1234);
        csr_wr(A_TD1, 32'h2800_1044);
        d_mode = 0; m_mode = 1;
        csr_wr(A_TD2, 32'hdead);
        csr_rd(A_TD2, rd);
        checks++;
        if (rd !== 32'h1234) begin errors++; $display("FAIL prot_tdata2 got %h want 1234", rd); end
        csr_wr(A_TD1, 32'h0);
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h2BE0_1044) begin errors++; $display("FAIL prot_tdata1 got %h want 2be01044", rd); end
        d_mode = 1;
        csr_wr(A_TD1, 32'h2000_1000);
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h23E0_0000) begin errors++; $display("FAIL legal_action got %h want 23e00000", rd); end
        csr_wr(A_TD1, 32'h2000_0280);
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h23E0_0000) begin errors++; $display("FAIL legal_match got %h want 23e00000", rd); end
        csr_wr(A_TSEL, 32'd3);
        csr_wr(A_TD1, 32'h2000_0800);
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h23E0_0000) begin errors++; $display("FAIL legal_chain got %h want 23e00000", rd); end
        d_mode = 0;
    endtask

    task automatic test_icount();
        d_mode = 0; m_mode = 1; trig_m_en = 1;
        csr_wr(A_TSEL, 32'd4);
        csr_wr(A_TD1, 32'h3000_0E00);
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h3000_0E00) begin errors++; $display("FAIL icount_cfg got %h want 30000e00", rd); end
        retire = 1;
        tick();
        tick();
        checks++;
        if (break_icount !== 1'b0) begin errors++; $display("FAIL icount_early got %b want 0", break_icount); end
        tick();
        retire = 0;
        checks++;
        if ({break_icount, break_d_mode} !== 2'b10) begin
            errors++; $display("FAIL icount_fire icount/dmode got %b want 10", {break_icount, break_d_mode});
        end
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h3100_0200) begin errors++; $display("FAIL icount_hit got %h want 31000200", rd); end
        trap_enter = 1;
        tick();
        trap_enter = 0;
        checks++;
        if (break_icount !== 1'b0) begin errors++; $display("FAIL icount_trap got %b want 0", break_icount); end
        retire = 1;
        csr_wr(A_TD1, 32'h3000_1600);
        retire = 0;
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h3000_1600) begin errors++; $display("FAIL icount_wr_wins got %h want 30001600", rd); end
        retire = 1;
        tick();
        retire = 0;
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h3000_1200) begin errors++; $display("FAIL icount_dec got %h want 30001200", rd); end
        csr_wr(A_TD1, 32'h3000_0600);
        retire = 1;
        tick();
        retire = 0;
        checks++;
        if (break_icount !== 1'b1) begin errors++; $display("FAIL icount_one got %b want 1", break_icount); end
        csr_wr(A_TD1, 32'h3000_0200);
        checks++;
        if (break_icount !== 1'b0) begin errors++; $display("FAIL icount_wrclr got %b want 0", break_icount); end
        retire = 1;
        tick();
        tick();
        retire = 0;
        checks++;
        if (break_icount !== 1'b0) begin errors++; $display("FAIL icount_zero got %b want 0", break_icount); end
    endtask

    task automatic test_tselect_range();
        csr_wr(A_TSEL, 32'd7);
        csr_rd(A_TSEL, rd);
        checks++;
        if (rd !== 32'd7) begin errors++; $display("FAIL tsel_read got %h want 7", rd); end
        csr_rd(A_INFO, rd);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL tsel_tinfo got %h want 1", rd); end
        csr_wr(A_TD1, 32'hFFFF_FFFF);
        csr_wr(A_TD2, 32'hFFFF_FFFF);
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL tsel_tdata1 got %h want 0", rd); end
        csr_rd(A_TD2, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL tsel_tdata2 got %h want 0", rd); end
        csr_wr(A_TSEL, 32'd0);
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h23E0_0000) begin errors++; $display("FAIL tsel_noeffect got %h want 23e00000", rd); end
        csr_wr(A_TSEL, 32'h0000_000C);
        csr_rd(A_TSEL, rd);
        checks++;
        if (rd !== 32'd4) begin errors++; $display("FAIL tsel_trunc got %h want 4", rd); end
        csr_rd(A_INFO, rd);
        checks++;
        if (rd !== 32'd8) begin errors++; $display("FAIL tsel_icinfo got %h want 8", rd); end
    endtask

    task automatic test_async_reset();
        d_mode = 0; m_mode = 1; trig_m_en = 1;
        csr_wr(A_TSEL, 32'd4);
        csr_wr(A_TD1, 32'h3000_0600);
        retire = 1;
        tick();
        retire = 0;
        csr_wr(A_TSEL, 32'd0);
        csr_wr(A_TD2, 32'h100);
        csr_wr(A_TD1, 32'h2000_0044);
        exec_pc = 32'h100; exec_valid = 1;
        #1;
        checks++;
        if ({break_exec, break_icount} !== 2'b11) begin
            errors++; $display("FAIL arst_armed exec/icount got %b want 11", {break_exec, break_icount});
        end
        rst_n = 0;
        #1;
        checks++;
        if ({break_exec, break_mem, break_icount, break_d_mode} !== 4'b0000) begin
            errors++;
            $display("FAIL arst_outputs got %b want 0000",
                     {break_exec, break_mem, break_icount, break_d_mode});
        end
        csr_wr(A_TSEL, 32'd4);
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h23E0_0000) begin errors++; $display("FAIL arst_tdata1 got %h want 23e00000", rd); end
        exec_valid = 0;
        @(negedge clk);
        rst_n = 1;
        tick();
        csr_wr(A_TSEL, 32'd4);
        csr_rd(A_TD1, rd);
        checks++;
        if (rd !== 32'h3000_0000) begin errors++; $display("FAIL arst_icount got %h want 30000000", rd); end
    endtask

    initial begin
        rst_n = 0;
        trig_m_en = 0; m_mode = 0; d_mode = 0;
        exec_pc = '0; exec_valid = 0;
        mem_addr = '0; mem_valid = 0; mem_write = 0;
        retire = 0; trap_enter = 0;
        cfg_if.cfg_addr = '0; cfg_if.cfg_wen = 0; cfg_if.cfg_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        tick();
        test_reset();
        test_exec_exact();
        test_napot();
        test_chain();
        test_protection();
        test_icount();
        test_tselect_range();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
